control_unit: RTL and testbench
===============================

# control_unit

Hardwired multi-cycle sequencer for the three-bus datapath. It fetches each instruction through MA/MD into IR, then decodes IR and drives every datapath select and enable for one instruction at a time. It also drives the memory write strobe and halts on `halt`. It sits beside the datapath: it reads the IR value from the datapath and feeds all control inputs back to it.

## Interface
- `MEM_WAIT`, default 1: idle cycles between MA load and `md_in_memory`, range 0..7 (memory read latency minus one).
- `clk`  input  1  rising-edge clock shared with the datapath.
- `clr`  input  1  one clock; reset is asynchronous and active-low; also routed to the datapath, which clears PC to 0.
- `ir`  input  32  IR contents; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
- `ir_en`  output  1  IR load enable.
- `pc_increment`, `pc_in_alu`, `pc_in_rf_a`  output  1 each  PC source selects; `pc_in_alu` is tied 0 in this revision.
- `ma_in_pc`, `ma_in_alu`  output  1 each  MA source selects.
- `md_in_memory`, `md_in_rf_b`  output  1 each  MD source selects.
- `alu_a_in_rf`, `alu_a_in_pc`, `alu_b_in_rf`, `alu_b_in_constant`  output  1 each  ALU operand selects.
- `hi_en`, `lo_en`  output  1 each  HI/LO load enables.
- `rf_in_alu`, `rf_in_hi`, `rf_in_lo`, `rf_in_md`  output  1 each  register-file write source; at most one is high.
- `rf_a_addr`, `rf_b_addr`, `rf_z_addr`  output  4 each  register-file read A, read B and write addresses.
- `alu_select`  output  12  one-hot select; bit 11 down to bit 0 = add, sub, shr, shl, ror, rol, and, or, mul, div, neg, not.
- `constant_c`  output  32  C sign-extended from bit 18.
- `mem_write`  output  1  memory writes MD to address MA on the rising edge where this is high.
- `halted`  output  1  high in HALT.

## Operation
- Moore FSM. Outputs decode from the state and the registered `ir`. Any output not named for a state is 0.
- A 3-bit wait counter provides the MEM_WAIT idle cycles.
- States:
  - RST: all outputs 0. Exits to F0 on the first edge after `clr` rises.
  - F0: `ma_in_pc`, `pc_increment`.
  - FW: idle for MEM_WAIT cycles; skipped when MEM_WAIT=0.
  - FM: `md_in_memory`.
  - FI: `ir_en`.
  - E0: execute, decoded from opcode.
- E0 by opcode, followed by F0 unless a later state is listed:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010: rf_a=Rb, rf_b=Rc, `alu_a_in_rf`, `alu_b_in_rf`, `rf_in_alu`, rf_z=Ra.
  - addi 01011, andi 01100, ori 01101, ldi 00001: rf_a=Rb, `alu_a_in_rf`, `alu_b_in_constant`, `rf_in_alu`, rf_z=Ra. ALU op is add, and or or; ldi uses add.
  - neg 10000, not 10001: rf_a=Rb, `alu_a_in_rf`, `rf_in_alu`, rf_z=Ra.
  - mul 01110, div 01111: rf_a=Ra, rf_b=Rb, `alu_a_in_rf`, `alu_b_in_rf`, `hi_en`, `lo_en`.
  - mfhi 10111, mflo 11000: `rf_in_hi` or `rf_in_lo`, rf_z=Ra.
  - jr 10011: rf_a=Ra, `pc_in_rf_a`.
  - jal 10100: rf_a=Ra, `pc_in_rf_a`, `alu_a_in_pc`, `alu_b_in_constant`, constant_c=0, add, `rf_in_alu`, rf_z=15. r15 receives the pre-jump PC (already +4).
  - ld 00000: E0 drives rf_a=Rb, `alu_a_in_rf`, `alu_b_in_constant`, add, `ma_in_alu`. Then LW (MEM_WAIT cycles), then LM (`md_in_memory`), then LR (`rf_in_md`, rf_z=Ra).
  - st 00010: E0 drives the same address path as ld, plus rf_b=Ra and `md_in_rf_b`. Then S1 (`mem_write`).
  - halt 11010: enter HALT, which holds `halted`=1 with all enables 0 until `clr` is low.
  - nop 11001 and every other opcode: no enables; return to F0.
- `constant_c` is valid only in E0 of ld, st, ldi, addi, andi and ori (0 for jal); it is 0 in all other states.
- `alu_select` is 0 outside E0.

## Timing
- `clr` low forces RST immediately, regardless of clock, from any state including mid-ld or mid-st. A pending `mem_write` drops within the same cycle.
- Fetch takes 3+MEM_WAIT cycles.
- Instruction cost (cycles, F0 through last execute state):
  - R-type, immediate, neg/not, mul/div, mfhi/mflo, jr, jal, nop: 4+MEM_WAIT.
  - st: 5+MEM_WAIT.
  - ld: 6+2·MEM_WAIT.
- `ir` is sampled only in E0 and later states, never during fetch.
- The PC update and the r15 write of jal occur on the same edge.

## Test plan
- Reset mid-ld: pulse `clr` low during LW → all outputs 0 asynchronously. One edge after release, FSM is in F0 with `ma_in_pc`=`pc_increment`=1; `halted`=0.
- add r3,r1,r2 (ir=0x19890000, MEM_WAIT=1) → cycle 5: rf_a_addr=1, rf_b_addr=2, rf_z_addr=3, alu_select=0x800, `rf_in_alu`=1; cycle 6: F0.
- ld r2,0x10(r1) (ir=0x01080010, MEM_WAIT=1) → cycle 5: `ma_in_alu`, constant_c=0x00000010; cycle 7: `md_in_memory`; cycle 8: `rf_in_md`, rf_z_addr=2; cycle 9: F0. Repeat with MEM_WAIT=0 and 3: ld takes 6 and 12 cycles.
- addi r1,r1,-1 (C=0x7FFFF) → constant_c=0xFFFFFFFF, alu_select=0x800. andi with C=0x0000F → constant_c=0x0000000F, alu_select=0x020.
- mul r1,r2 then mfhi r5 → `hi_en`=`lo_en`=1 with alu_select=0x008; next E0: `rf_in_hi`, rf_z_addr=5. st r4,0(r6) → `mem_write` high for exactly one cycle, in S1.
- jal r4 → single E0 with `pc_in_rf_a`, rf_a_addr=4, `alu_a_in_pc`, rf_z_addr=15. halt → `halted`=1 and all enables 0 for 100 cycles, until `clr` is asserted.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired multi-cycle sequencer: fetch through MA/MD into IR, then decode IR and drive datapath controls.
// Latency: fetch 3+MEM_WAIT cycles; 1 execute cycle (st +1, ld +2+MEM_WAIT); outputs are Moore (state + IR).
// No backpressure: memory is fixed-latency; clr low forces RST asynchronously from any state.
module control_unit #(
   parameter int MEM_WAIT = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   output logic        ir_en,
   output logic        pc_increment,
   output logic        pc_in_alu,
   output logic        pc_in_rf_a,
   output logic        ma_in_pc,
   output logic        ma_in_alu,
   output logic        md_in_memory,
   output logic        md_in_rf_b,
   output logic        alu_a_in_rf,
   output logic        alu_a_in_pc,
   output logic        alu_b_in_rf,
   output logic        alu_b_in_constant,
   output logic        hi_en,
   output logic        lo_en,
   output logic        rf_in_alu,
   output logic        rf_in_hi,
   output logic        rf_in_lo,
   output logic        rf_in_md,
   output logic [3:0]  rf_a_addr,
   output logic [3:0]  rf_b_addr,
   output logic [3:0]  rf_z_addr,
   output logic [11:0] alu_select,
   output logic [31:0] constant_c,
   output logic        mem_write,
   output logic        halted
);

   localparam logic [3:0] S_RST  = 4'd0;
   localparam logic [3:0] S_F0   = 4'd1;
   localparam logic [3:0] S_FW   = 4'd2;
   localparam logic [3:0] S_FM   = 4'd3;
   localparam logic [3:0] S_FI   = 4'd4;
   localparam logic [3:0] S_E0   = 4'd5;
   localparam logic [3:0] S_LW   = 4'd6;
   localparam logic [3:0] S_LM   = 4'd7;
   localparam logic [3:0] S_LR   = 4'd8;
   localparam logic [3:0] S_S1   = 4'd9;
   localparam logic [3:0] S_HALT = 4'd10;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_MFHI = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11010;

   // One-hot ALU selects, add in bit 11 down to not in bit 0.
   localparam logic [11:0] ALU_ADD = 12'h800;
   localparam logic [11:0] ALU_SUB = 12'h400;
   localparam logic [11:0] ALU_SHR = 12'h200;
   localparam logic [11:0] ALU_SHL = 12'h100;
   localparam logic [11:0] ALU_ROR = 12'h080;
   localparam logic [11:0] ALU_ROL = 12'h040;
   localparam logic [11:0] ALU_AND = 12'h020;
   localparam logic [11:0] ALU_OR  = 12'h010;
   localparam logic [11:0] ALU_MUL = 12'h008;
   localparam logic [11:0] ALU_DIV = 12'h004;
   localparam logic [11:0] ALU_NEG = 12'h002;
   localparam logic [11:0] ALU_NOT = 12'h001;

   // Last count value of a wait state; unused when MEM_WAIT is 0 because the wait states are skipped.
   localparam logic [2:0] W_LAST = 3'(MEM_WAIT - 1);

   logic [3:0]  r_state;
   logic [3:0]  w_next;
   logic [2:0]  r_wait;
   logic [4:0]  w_op;
   logic [3:0]  w_ra;
   logic [3:0]  w_rb;
   logic [3:0]  w_rc;
   logic [31:0] w_cx;

   assign w_op = ir[31:27];
   assign w_ra = ir[26:23];
   assign w_rb = ir[22:19];
   assign w_rc = ir[18:15];
   assign w_cx = {{13{ir[18]}}, ir[18:0]};

   // Next-state sequencing; ir only matters from E0 onward.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:  w_next = S_F0;
         S_F0:   w_next = (MEM_WAIT == 0) ? S_FM : S_FW;
         S_FW:   if (r_wait == W_LAST) w_next = S_FM;
         S_FM:   w_next = S_FI;
         S_FI:   w_next = S_E0;
         S_E0: begin
            case (w_op)
               OP_LD:   w_next = (MEM_WAIT == 0) ? S_LM : S_LW;
               OP_ST:   w_next = S_S1;
               OP_HALT: w_next = S_HALT;
               default: w_next = S_F0;
            endcase
         end
         S_LW:   if (r_wait == W_LAST) w_next = S_LM;
         S_LM:   w_next = S_LR;
         S_LR:   w_next = S_F0;
         S_S1:   w_next = S_F0;
         S_HALT: w_next = S_HALT;
         default: w_next = S_RST;
      endcase
   end

   // State and wait counter; the counter runs only inside a wait state and is cleared everywhere else.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_RST;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= (r_state == S_FW || r_state == S_LW) ? r_wait + 3'd1 : 3'd0;
      end
   end

   assign pc_in_alu = 1'b0;

   // Moore output decode; anything not named for a state stays 0.
   always_comb begin
      ir_en = 1'b0;             pc_increment = 1'b0;     pc_in_rf_a = 1'b0;
      ma_in_pc = 1'b0;          ma_in_alu = 1'b0;
      md_in_memory = 1'b0;      md_in_rf_b = 1'b0;
      alu_a_in_rf = 1'b0;       alu_a_in_pc = 1'b0;
      alu_b_in_rf = 1'b0;       alu_b_in_constant = 1'b0;
      hi_en = 1'b0;             lo_en = 1'b0;
      rf_in_alu = 1'b0;         rf_in_hi = 1'b0;         rf_in_lo = 1'b0;  rf_in_md = 1'b0;
      rf_a_addr = 4'd0;         rf_b_addr = 4'd0;        rf_z_addr = 4'd0;
      alu_select = 12'd0;       constant_c = 32'd0;
      mem_write = 1'b0;         halted = 1'b0;
      case (r_state)
         S_F0: begin
            ma_in_pc     = 1'b1;
            pc_increment = 1'b1;
         end
         S_FM, S_LM: md_in_memory = 1'b1;
         S_FI: ir_en = 1'b1;
         S_E0: begin
            case (w_op)
               OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
                  rf_a_addr   = w_rb;
                  rf_b_addr   = w_rc;
                  rf_z_addr   = w_ra;
                  alu_a_in_rf = 1'b1;
                  alu_b_in_rf = 1'b1;
                  rf_in_alu   = 1'b1;
                  case (w_op)
                     OP_ADD:  alu_select = ALU_ADD;
                     OP_SUB:  alu_select = ALU_SUB;
                     OP_SHR:  alu_select = ALU_SHR;
                     OP_SHL:  alu_select = ALU_SHL;
                     OP_ROR:  alu_select = ALU_ROR;
                     OP_ROL:  alu_select = ALU_ROL;
                     OP_AND:  alu_select = ALU_AND;
                     default: alu_select = ALU_OR;
                  endcase
               end
               OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                  rf_a_addr         = w_rb;
                  rf_z_addr         = w_ra;
                  alu_a_in_rf       = 1'b1;
                  alu_b_in_constant = 1'b1;
                  rf_in_alu         = 1'b1;
                  constant_c        = w_cx;
                  alu_select        = (w_op == OP_ANDI) ? ALU_AND :
                                      (w_op == OP_ORI)  ? ALU_OR  : ALU_ADD;
               end
               OP_NEG, OP_NOT: begin
                  rf_a_addr   = w_rb;
                  rf_z_addr   = w_ra;
                  alu_a_in_rf = 1'b1;
                  rf_in_alu   = 1'b1;
                  alu_select  = (w_op == OP_NEG) ? ALU_NEG : ALU_NOT;
               end
               OP_MUL, OP_DIV: begin
                  rf_a_addr   = w_ra;
                  rf_b_addr   = w_rb;
                  alu_a_in_rf = 1'b1;
                  alu_b_in_rf = 1'b1;
                  hi_en       = 1'b1;
                  lo_en       = 1'b1;
                  alu_select  = (w_op == OP_MUL) ? ALU_MUL : ALU_DIV;
               end
               OP_MFHI: begin
                  rf_in_hi  = 1'b1;
                  rf_z_addr = w_ra;
               end
               OP_MFLO: begin
                  rf_in_lo  = 1'b1;
                  rf_z_addr = w_ra;
               end
               OP_JR: begin
                  rf_a_addr  = w_ra;
                  pc_in_rf_a = 1'b1;
               end
               // PC (already advanced) passes through the ALU into r15 on the same edge the jump loads PC.
               OP_JAL: begin
                  rf_a_addr         = w_ra;
                  pc_in_rf_a        = 1'b1;
                  alu_a_in_pc       = 1'b1;
                  alu_b_in_constant = 1'b1;
                  alu_select        = ALU_ADD;
                  rf_in_alu         = 1'b1;
                  rf_z_addr         = 4'd15;
               end
               OP_LD, OP_ST: begin
                  rf_a_addr         = w_rb;
                  alu_a_in_rf       = 1'b1;
                  alu_b_in_constant = 1'b1;
                  alu_select        = ALU_ADD;
                  ma_in_alu         = 1'b1;
                  constant_c        = w_cx;
                  if (w_op == OP_ST) begin
                     rf_b_addr  = w_ra;
                     md_in_rf_b = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         S_LR: begin
            rf_in_md  = 1'b1;
            rf_z_addr = w_ra;
         end
         S_S1:   mem_write = 1'b1;
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: three control_unit instances (MEM_WAIT 1, 0, 3) exercised one at a time.
// Stimulus pushes the expected per-cycle control vector of each instruction; a negedge monitor pops and compares.
// Reference model builds each instruction's vector sequence from the opcode rules, independent of FSM encoding.
module tb_control_unit;

   typedef struct packed {
      logic        ir_en, pc_increment, pc_in_alu, pc_in_rf_a, ma_in_pc, ma_in_alu, md_in_memory, md_in_rf_b;
      logic        alu_a_in_rf, alu_a_in_pc, alu_b_in_rf, alu_b_in_constant, hi_en, lo_en;
      logic        rf_in_alu, rf_in_hi, rf_in_lo, rf_in_md;
      logic [3:0]  rf_a_addr, rf_b_addr, rf_z_addr;
      logic [11:0] alu_select;
      logic [31:0] constant_c;
      logic        mem_write, halted;
   } ctl_t;

   logic        clk;
   logic        clr_v [3];
   logic [31:0] ir_v  [3];
   ctl_t        obs   [3];
   int          act;
   int          checks;
   int          failures;
   ctl_t        exp_q [$];
   ctl_t        mdl_q [$];
   ctl_t        mon_e;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int MW = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      logic        ir_en, pc_increment, pc_in_alu, pc_in_rf_a, ma_in_pc, ma_in_alu, md_in_memory, md_in_rf_b;
      logic        alu_a_in_rf, alu_a_in_pc, alu_b_in_rf, alu_b_in_constant, hi_en, lo_en;
      logic        rf_in_alu, rf_in_hi, rf_in_lo, rf_in_md;
      logic [3:0]  rf_a_addr, rf_b_addr, rf_z_addr;
      logic [11:0] alu_select;
      logic [31:0] constant_c;
      logic        mem_write, halted;

      control_unit #(.MEM_WAIT(MW)) u_dut (
         .clk(clk), .clr(clr_v[g]), .ir(ir_v[g]),
         .ir_en(ir_en), .pc_increment(pc_increment), .pc_in_alu(pc_in_alu), .pc_in_rf_a(pc_in_rf_a),
         .ma_in_pc(ma_in_pc), .ma_in_alu(ma_in_alu), .md_in_memory(md_in_memory), .md_in_rf_b(md_in_rf_b),
         .alu_a_in_rf(alu_a_in_rf), .alu_a_in_pc(alu_a_in_pc), .alu_b_in_rf(alu_b_in_rf),
         .alu_b_in_constant(alu_b_in_constant), .hi_en(hi_en), .lo_en(lo_en),
         .rf_in_alu(rf_in_alu), .rf_in_hi(rf_in_hi), .rf_in_lo(rf_in_lo), .rf_in_md(rf_in_md),
         .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr), .rf_z_addr(rf_z_addr),
         .alu_select(alu_select), .constant_c(constant_c), .mem_write(mem_write), .halted(halted)
      );

      assign obs[g] = {ir_en, pc_increment, pc_in_alu, pc_in_rf_a, ma_in_pc, ma_in_alu, md_in_memory, md_in_rf_b,
                       alu_a_in_rf, alu_a_in_pc, alu_b_in_rf, alu_b_in_constant, hi_en, lo_en,
                       rf_in_alu, rf_in_hi, rf_in_lo, rf_in_md,
                       rf_a_addr, rf_b_addr, rf_z_addr, alu_select, constant_c, mem_write, halted};
   end

   // Monitor: one expected vector per cycle while the scoreboard holds entries.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (obs[act] !== mon_e) begin
            failures++;
            $display("FAIL ctl inst=%0d t=%0t got=%h exp=%h", act, $time, obs[act], mon_e);
         end
      end
   end

   function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [18:0] c);
      return {op, ra, rb, c};
   endfunction

   // Reference model: full per-cycle control sequence of one instruction, F0 up to its last execute cycle.
   task automatic model(input logic [31:0] i, input int mw);
      ctl_t        c;
      logic [4:0]  op;
      logic [3:0]  ra, rb, rc;
      logic [31:0] cx;
      op = i[31:27]; ra = i[26:23]; rb = i[22:19]; rc = i[18:15];
      cx = {{13{i[18]}}, i[18:0]};
      mdl_q.delete();
      c = '0; c.ma_in_pc = 1'b1; c.pc_increment = 1'b1; mdl_q.push_back(c);
      c = '0;
      for (int w = 0; w < mw; w++) mdl_q.push_back(c);
      c = '0; c.md_in_memory = 1'b1; mdl_q.push_back(c);
      c = '0; c.ir_en = 1'b1; mdl_q.push_back(c);
      c = '0;
      if (op >= 5'd3 && op <= 5'd10) begin
         c.rf_a_addr = rb; c.rf_b_addr = rc; c.rf_z_addr = ra;
         c.alu_a_in_rf = 1'b1; c.alu_b_in_rf = 1'b1; c.rf_in_alu = 1'b1;
         c.alu_select = 12'h800 >> (op - 5'd3);
      end else if (op == 5'd11 || op == 5'd12 || op == 5'd13 || op == 5'd1) begin
         c.rf_a_addr = rb; c.rf_z_addr = ra;
         c.alu_a_in_rf = 1'b1; c.alu_b_in_constant = 1'b1; c.rf_in_alu = 1'b1; c.constant_c = cx;
         c.alu_select = (op == 5'd12) ? 12'h020 : ((op == 5'd13) ? 12'h010 : 12'h800);
      end else if (op == 5'd16 || op == 5'd17) begin
         c.rf_a_addr = rb; c.rf_z_addr = ra; c.alu_a_in_rf = 1'b1; c.rf_in_alu = 1'b1;
         c.alu_select = (op == 5'd16) ? 12'h002 : 12'h001;
      end else if (op == 5'd14 || op == 5'd15) begin
         c.rf_a_addr = ra; c.rf_b_addr = rb; c.alu_a_in_rf = 1'b1; c.alu_b_in_rf = 1'b1;
         c.hi_en = 1'b1; c.lo_en = 1'b1;
         c.alu_select = (op == 5'd14) ? 12'h008 : 12'h004;
      end else if (op == 5'd23 || op == 5'd24) begin
         c.rf_in_hi = (op == 5'd23); c.rf_in_lo = (op == 5'd24); c.rf_z_addr = ra;
      end else if (op == 5'd19) begin
         c.rf_a_addr = ra; c.pc_in_rf_a = 1'b1;
      end else if (op == 5'd20) begin
         c.rf_a_addr = ra; c.pc_in_rf_a = 1'b1; c.alu_a_in_pc = 1'b1; c.alu_b_in_constant = 1'b1;
         c.alu_select = 12'h800; c.rf_in_alu = 1'b1; c.rf_z_addr = 4'd15;
      end else if (op == 5'd0 || op == 5'd2) begin
         c.rf_a_addr = rb; c.alu_a_in_rf = 1'b1; c.alu_b_in_constant = 1'b1; c.alu_select = 12'h800;
         c.ma_in_alu = 1'b1; c.constant_c = cx;
         if (op == 5'd2) begin
            c.rf_b_addr = ra; c.md_in_rf_b = 1'b1;
         end
      end
      mdl_q.push_back(c);
      if (op == 5'd0) begin
         c = '0;
         for (int w = 0; w < mw; w++) mdl_q.push_back(c);
         c.md_in_memory = 1'b1; mdl_q.push_back(c);
         c = '0; c.rf_in_md = 1'b1; c.rf_z_addr = ra; mdl_q.push_back(c);
      end else if (op == 5'd2) begin
         c = '0; c.mem_write = 1'b1; mdl_q.push_back(c);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input string name, input ctl_t got, input ctl_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s inst=%0d got=%h exp=%h", name, act, got, want);
      end
   endtask

   // Called 1 time unit after the edge that enters F0; returns likewise at the next F0.
   task automatic run_instr(input logic [31:0] i, input int mw);
      ir_v[act] = i;
      model(i, mw);
      for (int k = 0; k < mdl_q.size(); k++) exp_q.push_back(mdl_q[k]);
      repeat (mdl_q.size()) step();
   endtask

   // Asynchronous clr pulse in the current cycle; outputs must drop before any clock edge.
   task automatic reset_pulse();
      exp_q.push_back('0);
      #1 clr_v[act] = 1'b0;
      #1 check_now("async_rst", obs[act], '0);
      #1 clr_v[act] = 1'b1;
      step();
   endtask

   // Run an instruction for `at` cycles, confirm the next cycle, then reset in the middle of it.
   task automatic abort_instr(input logic [31:0] i, input int mw, input int at);
      ir_v[act] = i;
      model(i, mw);
      for (int k = 0; k < at; k++) exp_q.push_back(mdl_q[k]);
      repeat (at) step();
      check_now("pre_rst", obs[act], mdl_q[at]);
      reset_pulse();
   endtask

   task automatic run_halt(input int mw);
      ctl_t h;
      run_instr(enc(5'b11010, 4'd0, 4'd0, 19'd0), mw);
      h = '0; h.halted = 1'b1;
      for (int k = 0; k < 100; k++) exp_q.push_back(h);
      ir_v[act] = 32'h0;
      repeat (100) step();
      reset_pulse();
   endtask

   task automatic run_random(input int n, input int mw);
      logic [4:0] op;
      for (int k = 0; k < n; k++) begin
         do op = 5'($urandom_range(0, 31)); while (op == 5'b11010);
         run_instr({op, 27'($urandom)}, mw);
      end
   endtask

   task automatic start_phase(input int k);
      act = k;
      exp_q.push_back('0);
      clr_v[k] = 1'b1;
      step();
   endtask

   task automatic end_phase();
      reset_pulse();
      clr_v[act] = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      act = 0;
      for (int k = 0; k < 3; k++) begin
         clr_v[k] = 1'b0;
         ir_v[k]  = 32'h0;
      end
      repeat (2) step();
      for (int k = 0; k < 3; k++) check_now("reset_state", obs[k], '0);

      // MEM_WAIT = 1: directed cases from the instruction set, random mix, resets mid-ld/mid-st, halt.
      start_phase(0);
      run_instr(32'h19890000, 1);
      run_instr(32'h01080010, 1);
      run_instr(enc(5'b01011, 4'd1, 4'd1, 19'h7FFFF), 1);
      run_instr(enc(5'b01100, 4'd2, 4'd3, 19'h0000F), 1);
      run_instr(enc(5'b01110, 4'd1, 4'd2, 19'd0), 1);
      run_instr(enc(5'b10111, 4'd5, 4'd0, 19'd0), 1);
      run_instr(enc(5'b00010, 4'd4, 4'd6, 19'd0), 1);
      run_instr(enc(5'b10100, 4'd4, 4'd0, 19'd0), 1);
      run_instr(enc(5'b11001, 4'd7, 4'd8, 19'h12345), 1);
      run_random(40, 1);
      abort_instr(32'h01080010, 1, 5);
      run_instr(32'h19890000, 1);
      abort_instr(enc(5'b00010, 4'd4, 4'd6, 19'h40000), 1, 5);
      run_instr(enc(5'b10011, 4'd9, 4'd0, 19'd0), 1);
      run_halt(1);
      run_instr(32'h19890000, 1);
      end_phase();

      // MEM_WAIT = 0: ld spans 6 cycles, no wait states anywhere.
      start_phase(1);
      run_instr(32'h01080010, 0);
      run_instr(enc(5'b00010, 4'd4, 4'd6, 19'd8), 0);
      run_random(15, 0);
      run_halt(0);
      end_phase();

      // MEM_WAIT = 3: ld spans 12 cycles.
      start_phase(2);
      run_instr(32'h01080010, 3);
      run_instr(enc(5'b00010, 4'd4, 4'd6, 19'd8), 3);
      run_random(15, 3);
      abort_instr(32'h01080010, 3, 8);
      run_instr(32'h01080010, 3);
      end_phase();

      step();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
